// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with busy scoreboard and post-reset clear sweep
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_next;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= AW'(1);
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            CLEAR: begin
                idx_next = idx + AW'(1);
                if (idx == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign ready = (state == RUN);

    // Register contents survive rst; only the sweep zeroes them. wr1 is applied last so it wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end else begin
                if (wr0_en && (wr0_addr != '0)) begin
                    regs[wr0_addr] <= wr0_data;
                end
                if (wr1_en && (wr1_addr != '0)) begin
                    regs[wr1_addr] <= wr1_data;
                end
            end
        end
    end

    // Alloc is applied after the write clears so a new producer keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (state == RUN) begin
            if (wr0_en) begin
                busy[wr0_addr] <= 1'b0;
            end
            if (wr1_en) begin
                busy[wr1_addr] <= 1'b0;
            end
            if (alloc_en && (alloc_addr != '0)) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if ((state == RUN) && (addr != '0)) begin
                if (wr1_en && (wr1_addr == addr)) begin
                    data = wr1_data;
                end else if (wr0_en && (wr0_addr == addr)) begin
                    data = wr0_data;
                end else begin
                    data = regs[addr];
                    bsy  = busy[addr];
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with directed vectors
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                ready;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Expectations queued during a cycle are compared at the following falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = rd_data[e.port*XLEN +: XLEN];
                1:       act = {31'b0, rd_busy[e.port]};
                default: act = {31'b0, ready};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int port, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic idle_inputs();
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        alloc_en = 0; alloc_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle_inputs();
        tick();
        tick();
        push(2, 0, 32'd0, "reset_ready");
        push(1, 0, 32'd0, "reset_busy0");
        rst = 1'b0;

        // 1: sweep length and contents
        set_rd(0, 3);
        for (int k = 0; k < NREGS - 1; k++) begin
            push(2, 0, 32'd0, "sweep_ready_low");
            if (k == 2) push(0, 0, 32'd0, "sweep_rd_zero");
            tick();
        end
        push(2, 0, 32'd1, "sweep_ready_high");
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a);
            set_rd(1, NREGS - 1 - a);
            push(0, 0, 32'd0, "clear_rd0");
            push(0, 1, 32'd0, "clear_rd1");
            tick();
        end

        // 2: basic writes through both ports
        wr0_en = 1; wr0_addr = 1; wr0_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        set_rd(0, 1);
        push(0, 0, 32'hDEADBEEF, "wr0_read");
        tick();
        wr1_en = 1; wr1_addr = 2; wr1_data = 32'h12345678;
        tick();
        idle_inputs();
        set_rd(0, 2); set_rd(1, 1);
        push(0, 0, 32'h12345678, "wr1_read_p0");
        push(0, 1, 32'hDEADBEEF, "wr1_read_p1");
        tick();

        // 3: same-address write collision, wr1 wins
        wr0_en = 1; wr0_addr = 4; wr0_data = 32'h11111111;
        wr1_en = 1; wr1_addr = 4; wr1_data = 32'h76767676;
        set_rd(0, 4); set_rd(1, 4);
        push(0, 0, 32'h76767676, "collide_bypass_p0");
        push(0, 1, 32'h76767676, "collide_bypass_p1");
        tick();
        idle_inputs();
        push(0, 0, 32'h76767676, "collide_stored");
        tick();

        // 4: x0 stays zero and never busy
        wr1_en = 1; wr1_addr = 0; wr1_data = 32'h98761234;
        set_rd(0, 0);
        push(0, 0, 32'd0, "x0_write_same");
        tick();
        idle_inputs();
        push(0, 0, 32'd0, "x0_write_next");
        alloc_en = 1; alloc_addr = 0;
        tick();
        idle_inputs();
        push(1, 0, 32'd0, "x0_alloc_busy");
        tick();

        // 5: busy scoreboard
        alloc_en = 1; alloc_addr = 5;
        tick();
        idle_inputs();
        set_rd(0, 5);
        push(1, 0, 32'd1, "alloc_busy");
        push(0, 0, 32'd0, "alloc_data");
        tick();
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hAAAA5555;
        push(1, 0, 32'd0, "wr_bypass_busy");
        push(0, 0, 32'hAAAA5555, "wr_bypass_data");
        tick();
        idle_inputs();
        push(1, 0, 32'd0, "wr_cleared_busy");
        push(0, 0, 32'hAAAA5555, "wr_stored");
        tick();
        alloc_en = 1; alloc_addr = 5;
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h12121212;
        push(1, 0, 32'd0, "alloc_wr_bypass_busy");
        tick();
        idle_inputs();
        push(1, 0, 32'd1, "alloc_wr_busy");
        push(0, 0, 32'h12121212, "alloc_wr_data");
        tick();

        // 6: reset mid-run restarts the sweep and ignores writes during it
        wr0_en = 1; wr0_addr = 1; wr0_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        set_rd(0, 1); set_rd(1, 5);
        push(0, 0, 32'hDEADBEEF, "pre_rst_reg1");
        push(1, 1, 32'd1, "pre_rst_busy5");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(2, 0, 32'd0, "rst_ready_low");
        push(1, 1, 32'd0, "rst_busy5");
        wr0_en = 1; wr0_addr = 1; wr0_data = 32'h55555555;
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99999999;
        alloc_en = 1; alloc_addr = 7;
        for (int k = 0; k < NREGS - 1; k++) begin
            push(2, 0, 32'd0, "resweep_ready_low");
            tick();
        end
        idle_inputs();
        push(2, 0, 32'd1, "resweep_ready_high");
        set_rd(0, 1); set_rd(1, 9);
        push(0, 0, 32'd0, "resweep_reg1");
        push(0, 1, 32'd0, "resweep_reg9");
        tick();
        set_rd(0, 7); set_rd(1, 5);
        push(1, 0, 32'd0, "resweep_busy7");
        push(1, 1, 32'd0, "resweep_busy5");
        push(0, 1, 32'd0, "resweep_reg5");
        tick();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
